// File: rtl/fetch_pkg.sv
// Shared types and decode helpers for the fetch/pre-decode stage.
// Instruction layout: opcode[15:12], rt[11:8], ra[7:4], rb[3:0], imm[7:0].
package fetch_pkg;

  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic {
    S_RUN    = 1'b0,
    S_HALTED = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rt;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [7:0] imm;
    logic       uses_ra;
    logic       uses_rb;
    logic       writes_rt;
    logic       is_ld_str;
    logic       is_fxu;
    logic       is_branch;
    logic       is_halt;
  } slot_dec_t;

  function automatic logic [3:0] get_opcode(input logic [15:0] instr);
    return instr[15:12];
  endfunction

  function automatic slot_dec_t decode_slot(input logic [15:0] instr);
    slot_dec_t d;
    d.opcode    = get_opcode(instr);
    d.rt        = instr[11:8];
    d.ra        = instr[7:4];
    d.rb        = instr[3:0];
    d.imm       = instr[7:0];
    d.uses_ra   = d.opcode inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 4'd10, 4'd11};
    d.uses_rb   = d.opcode inside {4'd0, 4'd1, 4'd4};
    d.writes_rt = d.opcode inside {4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6};
    d.is_ld_str = d.opcode inside {4'd2, 4'd3};
    d.is_fxu    = d.opcode inside {4'd0, 4'd1, 4'd4, 4'd5, 4'd6};
    d.is_branch = d.opcode inside {4'd8, 4'd9, 4'd10, 4'd11};
    d.is_halt   = (d.opcode == OP_HALT);
    return d;
  endfunction

endpackage

// File: rtl/group_dep_resolver.sv
// Intra-group dependency resolution: each slot's ra/rb is mapped to the ROB tag
// of the youngest older slot writing that register, else to the slot's own tag.
module group_dep_resolver #(
  parameter int FETCH_W   = 4,
  parameter int ROB_IDX_W = 4
) (
  input  logic [FETCH_W*4-1:0]         rt_flat,
  input  logic [FETCH_W*4-1:0]         ra_flat,
  input  logic [FETCH_W*4-1:0]         rb_flat,
  input  logic [FETCH_W-1:0]           writes_rt,
  input  logic [FETCH_W-1:0]           uses_ra,
  input  logic [FETCH_W-1:0]           uses_rb,
  input  logic [ROB_IDX_W-1:0]         rob_tail,
  output logic [FETCH_W-1:0]           ra_dep,
  output logic [FETCH_W-1:0]           rb_dep,
  output logic [FETCH_W*ROB_IDX_W-1:0] ra_owner_flat,
  output logic [FETCH_W*ROB_IDX_W-1:0] rb_owner_flat
);

  // NOTE: every output gets a default before the loops so no path leaves it unassigned (no latch).
  always_comb begin
    ra_dep        = '0;
    rb_dep        = '0;
    ra_owner_flat = '0;
    rb_owner_flat = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      ra_owner_flat[ROB_IDX_W*i +: ROB_IDX_W] = rob_tail + ROB_IDX_W'(i);
      rb_owner_flat[ROB_IDX_W*i +: ROB_IDX_W] = rob_tail + ROB_IDX_W'(i);
      // Ascending scan: a later (younger) matching producer overrides an earlier one.
      for (int j = 0; j < FETCH_W; j++) begin
        if (j < i && writes_rt[j]) begin
          if (uses_ra[i] && rt_flat[4*j +: 4] == ra_flat[4*i +: 4]) begin
            ra_dep[i] = 1'b1;
            ra_owner_flat[ROB_IDX_W*i +: ROB_IDX_W] = rob_tail + ROB_IDX_W'(j);
          end
          if (uses_rb[i] && rt_flat[4*j +: 4] == rb_flat[4*i +: 4]) begin
            rb_dep[i] = 1'b1;
            rb_owner_flat[ROB_IDX_W*i +: ROB_IDX_W] = rob_tail + ROB_IDX_W'(j);
          end
        end
      end
    end
  end

endmodule

// File: rtl/fetch_group_unit.sv
// Fetch/pre-decode stage: sizes each group to buffer space and the first halt,
// resolves intra-group dependencies and registers the decoded group.
module fetch_group_unit
  import fetch_pkg::*;
#(
  parameter int FETCH_W   = 4,
  parameter int PC_W      = 16,
  parameter int ROB_IDX_W = 4,
  localparam int CNT_W    = $clog2(FETCH_W + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         redirect_valid,
  input  logic [PC_W-1:0]              redirect_pc,
  input  logic [CNT_W-1:0]             ib_free,
  input  logic [ROB_IDX_W-1:0]         rob_tail,
  output logic [FETCH_W*PC_W-1:0]      pc_to_icache_flat,
  input  logic [FETCH_W*16-1:0]        instr_flat,
  output logic [CNT_W-1:0]             out_cnt,
  output logic [FETCH_W*4-1:0]         opcode_out_flat,
  output logic [FETCH_W*4-1:0]         rt_out_flat,
  output logic [FETCH_W*4-1:0]         ra_out_flat,
  output logic [FETCH_W*4-1:0]         rb_out_flat,
  output logic [FETCH_W*8-1:0]         imm_out_flat,
  output logic [FETCH_W-1:0]           ra_dep_out_flat,
  output logic [FETCH_W-1:0]           rb_dep_out_flat,
  output logic [FETCH_W*ROB_IDX_W-1:0] ra_owner_out_flat,
  output logic [FETCH_W*ROB_IDX_W-1:0] rb_owner_out_flat,
  output logic [FETCH_W-1:0]           uses_ra_out_flat,
  output logic [FETCH_W-1:0]           uses_rb_out_flat,
  output logic [FETCH_W-1:0]           writes_rt_out_flat,
  output logic [FETCH_W-1:0]           is_ld_str_out_flat,
  output logic [FETCH_W-1:0]           is_fxu_out_flat,
  output logic [FETCH_W-1:0]           is_branch_out_flat,
  output logic [FETCH_W-1:0]           is_halt_out_flat,
  output logic                         halted
);

  fetch_state_e              state_q, state_d;
  logic [PC_W-1:0]           pc_q, pc_d;
  logic [CNT_W-1:0]          lim, n_run, cnt_d;
  logic                      halt_hit;
  slot_dec_t                 dec [FETCH_W];
  logic [FETCH_W*4-1:0]      rt_flat, ra_flat, rb_flat;
  logic [FETCH_W-1:0]        wr_v, ura_v, urb_v, ra_dep, rb_dep;
  logic [FETCH_W*ROB_IDX_W-1:0] ra_own, rb_own;

  always_comb begin
    pc_to_icache_flat = '0;
    rt_flat = '0;
    ra_flat = '0;
    rb_flat = '0;
    wr_v    = '0;
    ura_v   = '0;
    urb_v   = '0;
    for (int i = 0; i < FETCH_W; i++) begin
      pc_to_icache_flat[PC_W*i +: PC_W] = pc_q + PC_W'(2 * i);
      dec[i]         = decode_slot(instr_flat[16*i +: 16]);
      rt_flat[4*i +: 4] = dec[i].rt;
      ra_flat[4*i +: 4] = dec[i].ra;
      rb_flat[4*i +: 4] = dec[i].rb;
      wr_v[i]  = dec[i].writes_rt;
      ura_v[i] = dec[i].uses_ra;
      urb_v[i] = dec[i].uses_rb;
    end
  end

  group_dep_resolver #(.FETCH_W(FETCH_W), .ROB_IDX_W(ROB_IDX_W)) u_dep (
    .rt_flat       (rt_flat),
    .ra_flat       (ra_flat),
    .rb_flat       (rb_flat),
    .writes_rt     (wr_v),
    .uses_ra       (ura_v),
    .uses_rb       (urb_v),
    .rob_tail      (rob_tail),
    .ra_dep        (ra_dep),
    .rb_dep        (rb_dep),
    .ra_owner_flat (ra_own),
    .rb_owner_flat (rb_own)
  );

  // Group size: buffer space capped at FETCH_W, then cut just after the first halt.
  always_comb begin
    lim      = (ib_free > CNT_W'(FETCH_W)) ? CNT_W'(FETCH_W) : ib_free;
    n_run    = '0;
    halt_hit = 1'b0;
    for (int i = 0; i < FETCH_W; i++) begin
      if (!halt_hit && i < int'(lim)) begin
        n_run    = CNT_W'(i + 1);
        halt_hit = dec[i].is_halt;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = '0;
    if (redirect_valid) begin
      state_d = S_RUN;
      pc_d    = redirect_pc;
    end else if (state_q == S_RUN) begin
      cnt_d = n_run;
      pc_d  = pc_q + (PC_W'(n_run) << 1);
      if (halt_hit) state_d = S_HALTED;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  assign halted = (state_q == S_HALTED);

  // Slots beyond the group are cleared so the consumer never sees stale fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_cnt            <= '0;
      opcode_out_flat    <= '0;
      rt_out_flat        <= '0;
      ra_out_flat        <= '0;
      rb_out_flat        <= '0;
      imm_out_flat       <= '0;
      ra_dep_out_flat    <= '0;
      rb_dep_out_flat    <= '0;
      ra_owner_out_flat  <= '0;
      rb_owner_out_flat  <= '0;
      uses_ra_out_flat   <= '0;
      uses_rb_out_flat   <= '0;
      writes_rt_out_flat <= '0;
      is_ld_str_out_flat <= '0;
      is_fxu_out_flat    <= '0;
      is_branch_out_flat <= '0;
      is_halt_out_flat   <= '0;
    end else begin
      out_cnt <= cnt_d;
      for (int i = 0; i < FETCH_W; i++) begin
        if (i < int'(cnt_d)) begin
          opcode_out_flat[4*i +: 4]   <= dec[i].opcode;
          rt_out_flat[4*i +: 4]       <= dec[i].rt;
          ra_out_flat[4*i +: 4]       <= dec[i].ra;
          rb_out_flat[4*i +: 4]       <= dec[i].rb;
          imm_out_flat[8*i +: 8]      <= dec[i].imm;
          ra_dep_out_flat[i]          <= ra_dep[i];
          rb_dep_out_flat[i]          <= rb_dep[i];
          ra_owner_out_flat[ROB_IDX_W*i +: ROB_IDX_W] <= ra_own[ROB_IDX_W*i +: ROB_IDX_W];
          rb_owner_out_flat[ROB_IDX_W*i +: ROB_IDX_W] <= rb_own[ROB_IDX_W*i +: ROB_IDX_W];
          uses_ra_out_flat[i]         <= dec[i].uses_ra;
          uses_rb_out_flat[i]         <= dec[i].uses_rb;
          writes_rt_out_flat[i]       <= dec[i].writes_rt;
          is_ld_str_out_flat[i]       <= dec[i].is_ld_str;
          is_fxu_out_flat[i]          <= dec[i].is_fxu;
          is_branch_out_flat[i]       <= dec[i].is_branch;
          is_halt_out_flat[i]         <= dec[i].is_halt;
        end else begin
          opcode_out_flat[4*i +: 4]   <= '0;
          rt_out_flat[4*i +: 4]       <= '0;
          ra_out_flat[4*i +: 4]       <= '0;
          rb_out_flat[4*i +: 4]       <= '0;
          imm_out_flat[8*i +: 8]      <= '0;
          ra_dep_out_flat[i]          <= 1'b0;
          rb_dep_out_flat[i]          <= 1'b0;
          ra_owner_out_flat[ROB_IDX_W*i +: ROB_IDX_W] <= '0;
          rb_owner_out_flat[ROB_IDX_W*i +: ROB_IDX_W] <= '0;
          uses_ra_out_flat[i]         <= 1'b0;
          uses_rb_out_flat[i]         <= 1'b0;
          writes_rt_out_flat[i]       <= 1'b0;
          is_ld_str_out_flat[i]       <= 1'b0;
          is_fxu_out_flat[i]          <= 1'b0;
          is_branch_out_flat[i]       <= 1'b0;
          is_halt_out_flat[i]         <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_group_unit.sv
// Self-checking bench: directed scenarios with literal expectations, then random
// traffic compared every cycle against a table-driven behavioural model.
module tb_fetch_group_unit;

  localparam int FW = 4;

  logic        clk = 1'b0;
  logic        rst, redirect_valid;
  logic [15:0] redirect_pc;
  logic [2:0]  ib_free;
  logic [3:0]  rob_tail;
  logic [63:0] pc_to_icache_flat, instr_flat;
  logic [2:0]  out_cnt;
  logic [15:0] opcode_o, rt_o, ra_o, rb_o, ra_own_o, rb_own_o;
  logic [31:0] imm_o;
  logic [3:0]  ra_dep_o, rb_dep_o, ura_o, urb_o, wrt_o, ldst_o, fxu_o, br_o, hlt_o;
  logic        halted;

  fetch_group_unit #(.FETCH_W(4), .PC_W(16), .ROB_IDX_W(4)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .ib_free(ib_free), .rob_tail(rob_tail), .pc_to_icache_flat(pc_to_icache_flat),
    .instr_flat(instr_flat), .out_cnt(out_cnt), .opcode_out_flat(opcode_o),
    .rt_out_flat(rt_o), .ra_out_flat(ra_o), .rb_out_flat(rb_o), .imm_out_flat(imm_o),
    .ra_dep_out_flat(ra_dep_o), .rb_dep_out_flat(rb_dep_o),
    .ra_owner_out_flat(ra_own_o), .rb_owner_out_flat(rb_own_o),
    .uses_ra_out_flat(ura_o), .uses_rb_out_flat(urb_o), .writes_rt_out_flat(wrt_o),
    .is_ld_str_out_flat(ldst_o), .is_fxu_out_flat(fxu_o), .is_branch_out_flat(br_o),
    .is_halt_out_flat(hlt_o), .halted(halted)
  );

  always #5 clk = ~clk;

  // Opcode class membership tables, bit k set when opcode k belongs to the class.
  localparam logic [15:0] C_USES_RA = 16'h0F1F;
  localparam logic [15:0] C_USES_RB = 16'h0013;
  localparam logic [15:0] C_WRITES  = 16'h0077;
  localparam logic [15:0] C_LDST    = 16'h000C;
  localparam logic [15:0] C_FXU     = 16'h0073;
  localparam logic [15:0] C_BR      = 16'h0F00;
  localparam logic [15:0] C_HALT    = 16'h8000;

  int n_vec  = 0;
  int n_fail = 0;

  int          m_pc;
  bit          m_halted;
  bit          m_known = 1'b0;
  int          exp_cnt;
  logic [42:0] exp_slot [FW];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [42:0] dut_slot(input int i);
    return {opcode_o[4*i +: 4], rt_o[4*i +: 4], ra_o[4*i +: 4], rb_o[4*i +: 4],
            imm_o[8*i +: 8], ra_dep_o[i], rb_dep_o[i], ra_own_o[4*i +: 4], rb_own_o[4*i +: 4],
            ura_o[i], urb_o[i], wrt_o[i], ldst_o[i], fxu_o[i], br_o[i], hlt_o[i]};
  endfunction

  function automatic logic [63:0] model_pcs();
    logic [63:0] v;
    for (int i = 0; i < FW; i++) v[16*i +: 16] = 16'((m_pc + 2 * i) % 65536);
    return v;
  endfunction

  // Behavioural model: advance one cycle and produce the next registered group.
  task automatic model_step(input bit r, input bit rv, input logic [15:0] rpc,
                            input int fr, input int tail, input logic [63:0] ins);
    int n;
    bit hit;
    for (int i = 0; i < FW; i++) exp_slot[i] = '0;
    exp_cnt = 0;
    if (r) begin
      m_pc = 0; m_halted = 1'b0; m_known = 1'b1;
    end else if (rv) begin
      m_pc = int'(rpc); m_halted = 1'b0;
    end else if (!m_halted) begin
      n = (fr < FW) ? fr : FW;
      hit = 1'b0;
      for (int i = 0; i < n; i++)
        if (ins[16*i+12 +: 4] == 4'd15) begin n = i + 1; hit = 1'b1; break; end
      for (int i = 0; i < n; i++) begin
        int op, rt, ra, rb, own, rao, rbo;
        bit rad, rbd;
        op = int'(ins[16*i+12 +: 4]); rt = int'(ins[16*i+8 +: 4]);
        ra = int'(ins[16*i+4 +: 4]);  rb = int'(ins[16*i +: 4]);
        own = (tail + i) % 16;
        rad = 1'b0; rao = own; rbd = 1'b0; rbo = own;
        // Youngest older producer wins: search backwards and stop at first hit.
        for (int j = i - 1; j >= 0; j--)
          if (!rad && C_USES_RA[op] && C_WRITES[ins[16*j+12 +: 4]] && int'(ins[16*j+8 +: 4]) == ra) begin
            rad = 1'b1; rao = (tail + j) % 16;
          end
        for (int j = i - 1; j >= 0; j--)
          if (!rbd && C_USES_RB[op] && C_WRITES[ins[16*j+12 +: 4]] && int'(ins[16*j+8 +: 4]) == rb) begin
            rbd = 1'b1; rbo = (tail + j) % 16;
          end
        exp_slot[i] = {4'(op), 4'(rt), 4'(ra), 4'(rb), ins[16*i +: 8], rad, rbd, 4'(rao), 4'(rbo),
                       C_USES_RA[op], C_USES_RB[op], C_WRITES[op], C_LDST[op], C_FXU[op],
                       C_BR[op], C_HALT[op]};
      end
      exp_cnt = n;
      m_pc = (m_pc + 2 * n) % 65536;
      if (hit) m_halted = 1'b1;
    end
  endtask

  // One cycle: check the fetch PCs, drive, clock, then compare the registered group.
  task automatic step(input bit r, input bit rv, input logic [15:0] rpc,
                      input int fr, input int tail, input logic [63:0] ins);
    if (m_known) check("pc_to_icache", pc_to_icache_flat, model_pcs());
    rst = r; redirect_valid = rv; redirect_pc = rpc;
    ib_free = 3'(fr); rob_tail = 4'(tail); instr_flat = ins;
    model_step(r, rv, rpc, fr, tail, ins);
    @(posedge clk);
    #1;
    check("out_cnt", 64'(out_cnt), 64'(exp_cnt));
    check("halted", 64'(halted), 64'(m_halted));
    for (int i = 0; i < FW; i++) check($sformatf("slot%0d", i), 64'(dut_slot(i)), 64'(exp_slot[i]));
  endtask

  function automatic logic [15:0] rand_instr();
    logic [3:0] op;
    op = 4'($urandom_range(0, 15));
    if (op == 4'd15 && $urandom_range(0, 3) != 0) op = 4'd0;
    return {op, 2'b00, 2'($urandom_range(0, 3)), 2'b00, 2'($urandom_range(0, 3)),
            2'b00, 2'($urandom_range(0, 3))};
  endfunction

  localparam logic [15:0] ADD_R3 = 16'h0312;  // add r3 <- r1, r2
  logic [63:0] adds, dep_grp, halt_grp;

  initial begin
    adds     = {ADD_R3, ADD_R3, ADD_R3, ADD_R3};
    dep_grp  = {16'h2430, 16'h5300, ADD_R3, 16'h3000};  // slot3 ld ra=r3, slot2 writes r3
    halt_grp = {ADD_R3, ADD_R3, 16'hF000, ADD_R3};

    step(1, 1, 16'h1234, 4, 0, adds);
    step(1, 0, 16'h0, 4, 0, adds);
    check("reset_out_cnt", 64'(out_cnt), 64'd0);
    check("reset_pc0", 64'(pc_to_icache_flat[15:0]), 64'd0);
    check("reset_pc3", 64'(pc_to_icache_flat[63:48]), 64'd6);

    step(0, 0, 16'h0, 4, 0, adds);
    check("full_grp_cnt", 64'(out_cnt), 64'd4);
    check("full_grp_pc0", 64'(pc_to_icache_flat[15:0]), 64'd8);
    check("full_grp_pc3", 64'(pc_to_icache_flat[63:48]), 64'd14);

    step(0, 0, 16'h0, 2, 4, adds);
    check("half_grp_cnt", 64'(out_cnt), 64'd2);
    check("half_grp_pc0", 64'(pc_to_icache_flat[15:0]), 64'd12);
    step(0, 0, 16'h0, 0, 6, adds);
    check("no_space_cnt", 64'(out_cnt), 64'd0);
    check("no_space_pc0", 64'(pc_to_icache_flat[15:0]), 64'd12);

    step(0, 0, 16'h0, 4, 14, dep_grp);
    check("dep_ra_dep3", 64'(ra_dep_o[3]), 64'd1);
    check("dep_ra_own3", 64'(ra_own_o[15:12]), 64'd0);
    check("dep_own_tag1", 64'(rb_own_o[7:4]), 64'd15);

    step(0, 0, 16'h0, 4, 2, halt_grp);
    check("halt_cnt", 64'(out_cnt), 64'd2);
    check("halt_flag", 64'(halted), 64'd1);
    step(0, 0, 16'h0, 4, 4, adds);
    check("halted_cnt", 64'(out_cnt), 64'd0);

    step(0, 1, 16'h0040, 4, 4, adds);
    check("redir_cnt", 64'(out_cnt), 64'd0);
    check("redir_pc0", 64'(pc_to_icache_flat[15:0]), 64'h40);
    check("redir_run", 64'(halted), 64'd0);
    step(0, 0, 16'h0, 4, 4, adds);
    check("redir_grp_cnt", 64'(out_cnt), 64'd4);

    step(1, 1, 16'h0080, 4, 8, adds);
    check("midrst_cnt", 64'(out_cnt), 64'd0);
    check("midrst_pc0", 64'(pc_to_icache_flat[15:0]), 64'd0);
    check("midrst_opc", 64'(opcode_o), 64'd0);

    for (int c = 0; c < 3000; c++) begin
      logic [63:0] ins;
      for (int i = 0; i < FW; i++) ins[16*i +: 16] = rand_instr();
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0, 16'($urandom),
           int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), ins);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
